// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the core (priority) and a host
// debug/DMA port, with a starvation counter that forces an occasional host slot.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // core side
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [31:0]           core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_stall,
    // host side
    input  logic                  host_vld,
    output logic                  host_rdy,
    input  logic                  host_we,
    input  logic [31:0]           host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_rsp_vld,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_err,
    // RAM side
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_host;
    logic             grant_host;
    logic             grant_core;
    logic             misaligned;
    logic             wr_en_raw;
    logic             rsp_pend;
    logic             rsp_err;
    logic             rsp_rd;

    // Word addressing drops the byte offset and anything above the RAM depth.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{core_addr[31:ADDR_WIDTH+2], core_addr[1:0],
                                host_addr[31:ADDR_WIDTH+2]};

    assign misaligned = (host_addr[1:0] != 2'b00);

    always_comb begin
        force_host = host_vld && (starve_cnt == CNT_W'(STARVE_MAX));
        grant_host = force_host || (host_vld && !core_req);
        grant_core = core_req && !force_host;
    end

    assign core_stall = force_host & core_req;
    assign host_rdy   = grant_host;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a value held and no latch is inferred.
    always_comb begin
        ram_addr  = core_addr[ADDR_WIDTH+1:2];
        ram_din   = core_wdata;
        wr_en_raw = 1'b0;
        if (grant_host) begin
            ram_addr  = host_addr[ADDR_WIDTH+1:2];
            ram_din   = host_wdata;
            wr_en_raw = host_we & ~misaligned;
        end else if (grant_core) begin
            wr_en_raw = core_we;
        end
    end

    // Keeps the RAM from being written while reset is held, whatever the inputs do.
    assign ram_wr_en = wr_en_raw & rst_n;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            rsp_pend   <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rd     <= 1'b0;
        end else begin
            rsp_pend <= grant_host;
            rsp_err  <= grant_host & misaligned;
            rsp_rd   <= grant_host & ~misaligned & ~host_we;
            if (!host_vld || grant_host) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign host_rsp_vld = rsp_pend;
    assign host_err     = rsp_pend & rsp_err;
    assign host_rdata   = (rsp_pend && rsp_rd) ? ram_dout : '0;
    assign core_rdata   = ram_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a RAM model behind the arbiter, inline checks of
// the grant/RAM drive, and a scoreboard monitor for host responses and core reads.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_req, core_we;
    logic [31:0]   core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          core_stall;
    logic          host_vld, host_rdy, host_we;
    logic [31:0]   host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          host_rsp_vld, host_err;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_vld(host_vld), .host_rdy(host_rdy), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rsp_vld(host_rsp_vld), .host_rdata(host_rdata), .host_err(host_err),
        .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port RAM, read latency 1, contents survive reset.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int tests  = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    rsp_t host_q[$];

    // Core read expectation is raised in the grant cycle and latched at the edge.
    logic          core_chk_set = 1'b0;
    logic [DW-1:0] core_chk_exp = '0;
    logic          core_chk_v   = 1'b0;
    logic [DW-1:0] core_chk_d   = '0;
    always @(posedge clk) begin
        core_chk_v <= core_chk_set;
        core_chk_d <= core_chk_exp;
    end

    always @(negedge clk) begin
        if (host_rsp_vld) begin
            if (host_q.size() == 0) begin
                check("host_rsp_unexpected", 64'd1, 64'd0);
            end else begin
                rsp_t e;
                e = host_q.pop_front();
                check("host_rdata", host_rdata, e.rdata);
                check("host_err", host_err, e.err);
            end
        end else if (host_q.size() != 0) begin
            check("host_rsp_missing", 64'd0, 64'd1);
        end
        if (core_chk_v) check("core_rdata", core_rdata, core_chk_d);
    end

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [DW-1:0] cwd, input logic hvld, input logic hwe,
                         input logic [31:0] haddr, input logic [DW-1:0] hwd);
        @(negedge clk);
        core_req   = creq;  core_we   = cwe;  core_addr = caddr; core_wdata = cwd;
        host_vld   = hvld;  host_we   = hwe;  host_addr = haddr; host_wdata = hwd;
        core_chk_set = 1'b0;
        #1;
    endtask

    task automatic expect_host(input logic [DW-1:0] rd, input logic err);
        rsp_t e;
        e.rdata = rd;
        e.err   = err;
        host_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0, '0);
    endtask

    // Core holds a read of 0x7C (holds 0x1234) while the host reads haddr.
    task automatic contention(input logic [31:0] haddr, input logic [DW-1:0] exp_rd);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'h7C, '0, 1'b1, 1'b0, haddr, '0);
            check("cont_host_rdy_denied", host_rdy, 1'b0);
            check("cont_core_stall_0", core_stall, 1'b0);
            core_chk_set = 1'b1;
            core_chk_exp = 32'h1234;
        end
        drive(1'b1, 1'b0, 32'h7C, '0, 1'b1, 1'b0, haddr, '0);
        check("force_host_rdy", host_rdy, 1'b1);
        check("force_core_stall", core_stall, 1'b1);
        check("force_ram_addr", ram_addr, haddr[AW+1:2]);
        expect_host(exp_rd, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hBAD;
        host_vld = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        @(negedge clk); #1;
        check("rst_ram_wr_en_gated", ram_wr_en, 1'b0);
        check("rst_host_rsp_vld", host_rsp_vld, 1'b0);
        check("rst_host_err", host_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        core_req = 1'b0;

        // Host-only write then read.
        drive(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        check("hw_host_rdy", host_rdy, 1'b1);
        check("hw_ram_wr_en", ram_wr_en, 1'b1);
        check("hw_ram_addr", ram_addr, 5'd4);
        check("hw_ram_din", ram_din, 32'hDEADBEEF);
        expect_host(32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h10, '0);
        check("hr_host_rdy", host_rdy, 1'b1);
        check("hr_ram_wr_en", ram_wr_en, 1'b0);
        expect_host(32'hDEADBEEF, 1'b0);
        idle();

        // Core-only write then read at the top word.
        drive(1'b1, 1'b1, 32'h7C, 32'h1234, 1'b0, 1'b0, 32'h0, '0);
        check("cw_core_stall", core_stall, 1'b0);
        check("cw_ram_wr_en", ram_wr_en, 1'b1);
        check("cw_ram_addr", ram_addr, 5'd31);
        check("cw_ram_din", ram_din, 32'h1234);
        check("cw_host_rdy", host_rdy, 1'b0);
        drive(1'b1, 1'b0, 32'h7C, '0, 1'b0, 1'b0, 32'h0, '0);
        check("cr_core_stall", core_stall, 1'b0);
        check("cr_ram_wr_en", ram_wr_en, 1'b0);
        check("cr_ram_addr", ram_addr, 5'd31);
        core_chk_set = 1'b1;
        core_chk_exp = 32'h1234;
        idle();

        // Starvation: forced grant after 8 denials, then the counter restarts.
        contention(32'h0, 32'h0);
        contention(32'h10, 32'hDEADBEEF);
        idle();

        // Misaligned write is dropped; word 1 keeps its old value.
        drive(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 32'h06, 32'hAA);
        check("mis_host_rdy", host_rdy, 1'b1);
        check("mis_ram_wr_en", ram_wr_en, 1'b0);
        expect_host(32'h0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h04, '0);
        expect_host(32'h0, 1'b0);

        // Address wrap: 0x80 lands on word 0.
        drive(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b1, 32'h80, 32'h55);
        check("wrap_ram_addr", ram_addr, 5'd0);
        check("wrap_ram_wr_en", ram_wr_en, 1'b1);
        expect_host(32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0, '0);
        core_chk_set = 1'b1;
        core_chk_exp = 32'h55;
        // Misaligned read returns zero data even though word 0 is non-zero.
        drive(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h03, '0);
        check("misrd_ram_wr_en", ram_wr_en, 1'b0);
        expect_host(32'h0, 1'b1);
        idle();

        // Reset right after a host read is accepted: its response is discarded.
        drive(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h10, '0);
        check("prerst_host_rdy", host_rdy, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        host_vld = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hBAD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check("inrst_host_rsp_vld", host_rsp_vld, 1'b0);
            check("inrst_ram_wr_en", ram_wr_en, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        core_req = 1'b0; core_we = 1'b0;
        #1;
        check("postrst_host_rsp_vld", host_rsp_vld, 1'b0);
        drive(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h10, '0);
        check("postrst_host_rdy", host_rdy, 1'b1);
        expect_host(32'hDEADBEEF, 1'b0);
        idle();
        contention(32'h10, 32'hDEADBEEF);
        idle();
        idle();

        check("host_q_drained", host_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between the MIPS core and a host debug/DMA port. The RAM is word-addressed and has a read latency of 1.
- Sits between the core/program-controller mux and the data RAM instance.
- Priority scheme: the core has priority. The host gets idle slots. A starvation counter forces a host slot and stalls the core for one cycle.
- Host reads return one cycle after grant, with a response-valid strobe.

Parameters:
DATA_WIDTH, 32, data word width
ADDR_WIDTH, 5, RAM word-address width; byte addresses are 32 bit
STARVE_MAX, 8, consecutive denied host cycles before a forced host grant (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
core_req  in  1  core requests a data access this cycle
core_we  in  1  core write (1) / read (0)
core_addr  in  32  core byte address
core_wdata  in  DATA_WIDTH  core write data
core_rdata  out  DATA_WIDTH  core read data, valid the cycle after a granted core read
core_stall  out  1  core access this cycle not performed; core must hold request
host_vld  in  1  host request valid
host_rdy  out  1  host request accepted this cycle
host_we  in  1  host write (1) / read (0)
host_addr  in  32  host byte address
host_wdata  in  DATA_WIDTH  host write data
host_rsp_vld  out  1  host response strobe, one cycle after acceptance
host_rdata  out  DATA_WIDTH  host read data, valid with host_rsp_vld
host_err  out  1  with host_rsp_vld: request was misaligned and was dropped
ram_wr_en  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM word address
ram_din  out  DATA_WIDTH  RAM write data
ram_dout  in  DATA_WIDTH  RAM read data (latency 1)

Behaviour:
- Reset (async, rst_n=0) register values: starve_cnt=0, rsp_pend=0, rsp_err=0.
- Reset output values: host_rsp_vld=0, host_err=0. ram_wr_en is gated low while rst_n=0.
- Grant is combinational, one grant per cycle:
  - force = host_vld & (starve_cnt==STARVE_MAX). If force: grant host; core_stall = core_req.
  - Else if core_req: grant core; core_stall=0.
  - Else if host_vld: grant host.
  - Else: no grant; ram_wr_en=0, ram_addr=core_addr word, ram_din=core_wdata.
- host_rdy = host grant. A host transfer occurs when host_vld & host_rdy. The host must hold all request fields until host_rdy is seen.
- RAM drive on grant:
  - ram_addr = granted addr[ADDR_WIDTH+1:2]. Upper address bits are ignored; addresses wrap modulo 2^ADDR_WIDTH words.
  - ram_din = granted wdata.
  - ram_wr_en = granted we, except as noted for misaligned host requests.
- Misaligned host request (host_addr[1:0]!=0): accepted (host_rdy=1) with ram_wr_en forced 0. The next cycle gives host_rsp_vld=1, host_err=1, host_rdata=0.
- Misaligned core addresses are not checked; low bits are dropped.
- Host response:
  - rsp_pend registers the accepted host transfer; host_rsp_vld = rsp_pend, exactly 1 cycle after acceptance, for both reads and writes.
  - host_rdata = ram_dout when the transfer was an aligned read, else 0.
- core_rdata = ram_dout unconditionally. The core samples it only the cycle after its own granted read. A stalled core read has no valid data until the retried access is granted.
- starve_cnt:
  - Reset to 0 when host_vld=0 or the host is granted.
  - Otherwise (host_vld=1, core wins) increment, saturating at STARVE_MAX.
  - A forced grant therefore occurs on the cycle after STARVE_MAX consecutive denials. The counter returns to 0, giving at most one stall per STARVE_MAX+1 cycles.
- Simultaneous core_req and host_vld with starve_cnt<STARVE_MAX: the core wins, host_rdy=0, and starve_cnt increments.
- Back-to-back host transfers are allowed; host_rsp_vld may be high on consecutive cycles.
- Reset mid-operation: a pending response is discarded; no host_rsp_vld after reset release.

Test Plan:
- Host-only traffic: write 0xDEADBEEF @0x10, then read @0x10 → ram_wr_en=1 with ram_addr=4 on the first transfer; host_rsp_vld=1, host_rdata=0xDEADBEEF one cycle after the read.
- Core-only traffic: core writes 0x1234 @0x7C, then reads it back → core_stall never 1; core_rdata=0x1234 on the cycle after the read grant; ram_addr=31.
- Contention: core_req held 1 and host_vld=1 read @0x0, STARVE_MAX=8 → host_rdy=0 for 8 cycles; cycle 9 has host_rdy=1 and core_stall=1; the cycle after, core_stall=0 and starve_cnt=0.
- Misaligned host write 0xAA @0x06 → host_rdy=1, ram_wr_en=0; next cycle host_rsp_vld=1, host_err=1; word 1 unchanged on a later read.
- Address wrap: host write 0x55 @0x80 → lands at word 0; core read @0x0 returns 0x55.
- Reset asserted the cycle after a host read is accepted → host_rsp_vld=0 throughout and after reset; starve_cnt=0; first post-reset host request granted immediately if core idle.
